// File: rtl/idu_pkg.sv
// Shared decode constants for the ID stage: opcodes, control-bundle layout
// and the immediate-format selector used by the decoder.
package idu_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam int CTRL_W = 14;

    localparam int REG_WEN = 0;
    localparam int MEM_REN = 1;
    localparam int MEM_WEN = 2;
    localparam int BRANCH  = 3;
    localparam int JAL     = 4;
    localparam int JALR    = 5;
    localparam int LUI     = 6;
    localparam int AUIPC   = 7;
    localparam int SYSTEM  = 8;
    localparam int FENCE   = 9;
    localparam int CSR     = 10;
    localparam int R_TYPE  = 11;
    localparam int I_ALU   = 12;
    localparam int ILLEGAL = 13;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_e;

endpackage

// File: rtl/idu_decode.sv
// Combinational RV32I/RV32E decoder: control bundle, immediate and which
// source-register fields the instruction really reads.
module idu_decode
    import idu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
)
(
    input  logic [31:0]       i_inst,
    output logic [XLEN-1:0]   o_imm,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic              o_rs1_used,
    output logic              o_rs2_used
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    imm_fmt_e    w_fmt;
    logic [31:0] w_imm32;
    logic        w_known;
    logic        w_rd_written;
    logic        w_bad_reg;

    assign w_opcode = i_inst[6:0];
    assign w_funct3 = i_inst[14:12];
    assign w_rd     = i_inst[11:7];
    assign w_rs1    = i_inst[19:15];
    assign w_rs2    = i_inst[24:20];

    always_comb begin
        o_ctrl       = '0;
        w_fmt        = FMT_NONE;
        o_rs1_used   = 1'b0;
        o_rs2_used   = 1'b0;
        w_known      = 1'b1;
        w_rd_written = 1'b0;
        w_bad_reg    = 1'b0;
        case (w_opcode)
            OP_R: begin
                o_ctrl[R_TYPE] = 1'b1;
                w_rd_written   = 1'b1;
                o_rs1_used     = 1'b1;
                o_rs2_used     = 1'b1;
            end
            OP_IALU: begin
                o_ctrl[I_ALU] = 1'b1;
                w_fmt         = FMT_I;
                w_rd_written  = 1'b1;
                o_rs1_used    = 1'b1;
            end
            OP_LOAD: begin
                o_ctrl[MEM_REN] = 1'b1;
                w_fmt           = FMT_I;
                w_rd_written    = 1'b1;
                o_rs1_used      = 1'b1;
            end
            OP_STORE: begin
                o_ctrl[MEM_WEN] = 1'b1;
                w_fmt           = FMT_S;
                o_rs1_used      = 1'b1;
                o_rs2_used      = 1'b1;
            end
            OP_BRANCH: begin
                o_ctrl[BRANCH] = 1'b1;
                w_fmt          = FMT_B;
                o_rs1_used     = 1'b1;
                o_rs2_used     = 1'b1;
            end
            OP_JAL: begin
                o_ctrl[JAL]  = 1'b1;
                w_fmt        = FMT_J;
                w_rd_written = 1'b1;
            end
            OP_JALR: begin
                o_ctrl[JALR] = 1'b1;
                w_fmt        = FMT_I;
                w_rd_written = 1'b1;
                o_rs1_used   = 1'b1;
            end
            OP_LUI: begin
                o_ctrl[LUI]  = 1'b1;
                w_fmt        = FMT_U;
                w_rd_written = 1'b1;
            end
            OP_AUIPC: begin
                o_ctrl[AUIPC] = 1'b1;
                w_fmt         = FMT_U;
                w_rd_written  = 1'b1;
            end
            OP_SYSTEM: begin
                o_ctrl[SYSTEM] = 1'b1;
                w_fmt          = FMT_I;
                // CSR-immediate forms carry a zimm in the rs1 field, not a register
                if (w_funct3 != 3'd0) begin
                    o_ctrl[CSR]  = 1'b1;
                    w_rd_written = 1'b1;
                    o_rs1_used   = !w_funct3[2];
                end
            end
            OP_FENCE: begin
                o_ctrl[FENCE] = 1'b1;
            end
            default: begin
                w_known = 1'b0;
            end
        endcase

        w_bad_reg = (NREG < 32) &&
                    ((o_rs1_used   && (int'(w_rs1) >= NREG)) ||
                     (o_rs2_used   && (int'(w_rs2) >= NREG)) ||
                     (w_rd_written && (int'(w_rd)  >= NREG)));

        o_ctrl[REG_WEN] = w_rd_written && (w_rd != 5'd0);
        o_ctrl[ILLEGAL] = !w_known || (w_opcode[1:0] != 2'b11) || w_bad_reg;
        if (o_ctrl[ILLEGAL]) begin
            o_ctrl[REG_WEN] = 1'b0;
            o_ctrl[MEM_REN] = 1'b0;
            o_ctrl[MEM_WEN] = 1'b0;
        end
    end

    always_comb begin
        case (w_fmt)
            FMT_I:   w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
            FMT_S:   w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            FMT_B:   w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                                i_inst[30:25], i_inst[11:8], 1'b0};
            FMT_U:   w_imm32 = {i_inst[31:12], 12'd0};
            FMT_J:   w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                                i_inst[20], i_inst[30:21], 1'b0};
            default: w_imm32 = 32'd0;
        endcase
    end

    assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/idu_pipe.sv
// Registered instruction-decode stage: register file, generic forwarding with
// load-use interlock, one-entry valid/ready output register, stall counter.
module idu_pipe
    import idu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int NFWD  = 3,
    parameter int CNT_W = 16
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [31:0]          in_inst,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [31:0]          out_inst,
    output logic [XLEN-1:0]      out_rs1_data,
    output logic [XLEN-1:0]      out_rs2_data,
    output logic [XLEN-1:0]      out_imm,
    output logic [4:0]           out_rd,
    output logic [CTRL_W-1:0]    out_ctrl,
    input  logic                 rf_wen,
    input  logic [4:0]           rf_waddr,
    input  logic [XLEN-1:0]      rf_wdata,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD-1:0]      fwd_wen,
    input  logic [NFWD*5-1:0]    fwd_rd,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic [NFWD-1:0]      fwd_data_ok,
    input  logic                 flush,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam int RA_W = $clog2(NREG);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [XLEN-1:0]      r_rf [NREG];
    logic                 r_valid;
    logic [XLEN-1:0]      r_pc;
    logic [31:0]          r_inst;
    logic [XLEN-1:0]      r_rs1_data;
    logic [XLEN-1:0]      r_rs2_data;
    logic [XLEN-1:0]      r_imm;
    logic [4:0]           r_rd;
    logic [CTRL_W-1:0]    r_ctrl;
    logic [CNT_W-1:0]     r_stall_cnt;

    logic [XLEN-1:0]      w_imm;
    logic [CTRL_W-1:0]    w_ctrl;
    logic                 w_rs1_used;
    logic                 w_rs2_used;
    logic [1:0][4:0]      w_rs;
    logic [1:0]           w_used;
    logic [1:0][XLEN-1:0] w_opnd;
    logic [1:0]           w_fwd_hit;
    logic [1:0]           w_fwd_ok;
    logic                 w_hazard;
    logic                 w_accept;

    idu_decode #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_decode (
        .i_inst     (in_inst),
        .o_imm      (w_imm),
        .o_ctrl     (w_ctrl),
        .o_rs1_used (w_rs1_used),
        .o_rs2_used (w_rs2_used)
    );

    assign w_rs   = {in_inst[24:20], in_inst[19:15]};
    assign w_used = {w_rs2_used, w_rs1_used};

    // Sources are scanned oldest-first so the youngest match overwrites the rest.
    always_comb begin
        w_opnd    = '0;
        w_fwd_hit = '0;
        w_fwd_ok  = '1;
        w_hazard  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (w_rs[k] != 5'd0) begin
                if (rf_wen && (rf_waddr == w_rs[k])) begin
                    w_opnd[k] = rf_wdata;
                end else if (int'(w_rs[k]) < NREG) begin
                    w_opnd[k] = r_rf[w_rs[k][RA_W-1:0]];
                end
            end
            for (int i = NFWD - 1; i >= 0; i--) begin
                if (w_used[k] && fwd_valid[i] && fwd_wen[i] &&
                    (fwd_rd[i*5 +: 5] == w_rs[k]) && (w_rs[k] != 5'd0)) begin
                    w_opnd[k]    = fwd_data[i*XLEN +: XLEN];
                    w_fwd_hit[k] = 1'b1;
                    w_fwd_ok[k]  = fwd_data_ok[i];
                end
            end
            if (w_fwd_hit[k] && !w_fwd_ok[k]) begin
                w_hazard = 1'b1;
            end
        end
    end

    assign in_ready = !w_hazard && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < NREG; j++) begin
                r_rf[j] <= '0;
            end
        end else if (rf_wen && (rf_waddr != 5'd0) && (int'(rf_waddr) < NREG)) begin
            r_rf[rf_waddr[RA_W-1:0]] <= rf_wdata;
        end
    end

    // Flush beats accept and hold; the payload is only rewritten on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_inst     <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rd       <= '0;
            r_ctrl     <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid    <= 1'b1;
            r_pc       <= in_pc;
            r_inst     <= in_inst;
            r_rs1_data <= w_opnd[0];
            r_rs2_data <= w_opnd[1];
            r_imm      <= w_imm;
            r_rd       <= in_inst[11:7];
            r_ctrl     <= w_ctrl;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (in_valid && w_hazard && !flush && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign out_valid    = r_valid;
    assign out_pc       = r_pc;
    assign out_inst     = r_inst;
    assign out_rs1_data = r_rs1_data;
    assign out_rs2_data = r_rs2_data;
    assign out_imm      = r_imm;
    assign out_rd       = r_rd;
    assign out_ctrl     = r_ctrl;
    assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_idu_pipe.sv
// Bench for idu_pipe: directed scenarios on an RV32I and an RV32E instance,
// then randomized traffic against a behavioural model of the stage.
module tb_idu_pipe;

    localparam int cRegWen  = 0;
    localparam int cMemRen  = 1;
    localparam int cMemWen  = 2;
    localparam int cBranch  = 3;
    localparam int cJal     = 4;
    localparam int cJalr    = 5;
    localparam int cLui     = 6;
    localparam int cAuipc   = 7;
    localparam int cSystem  = 8;
    localparam int cFence   = 9;
    localparam int cCsr     = 10;
    localparam int cRType   = 11;
    localparam int cIAlu    = 12;
    localparam int cIllegal = 13;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic [31:0] inPc;
    logic [31:0] inInst;
    logic        outReady;
    logic        rfWen;
    logic [4:0]  rfWaddr;
    logic [31:0] rfWdata;
    logic [2:0]  fwdValid;
    logic [2:0]  fwdWen;
    logic [14:0] fwdRd;
    logic [95:0] fwdData;
    logic [2:0]  fwdOk;
    logic        flush;

    logic        inReady, outValid;
    logic [31:0] outPc, outInst, outRs1, outRs2, outImm;
    logic [4:0]  outRd;
    logic [13:0] outCtrl;
    logic [15:0] stallCnt;

    logic        inReady16, outValid16;
    logic [31:0] outPc16, outInst16, outRs1_16, outRs2_16, outImm16;
    logic [4:0]  outRd16;
    logic [13:0] outCtrl16;
    logic [1:0]  stallCnt16;

    int checkCount = 0;
    int failCount  = 0;

    logic [31:0] mRf [32];
    logic        mValid;
    logic [31:0] mPc, mInst, mRs1, mRs2, mImm;
    logic [4:0]  mRd;
    logic [13:0] mCtrl;
    int          mStall;

    idu_pipe #(.XLEN(32), .NREG(32), .NFWD(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
        .in_pc(inPc), .in_inst(inInst), .out_valid(outValid), .out_ready(outReady),
        .out_pc(outPc), .out_inst(outInst), .out_rs1_data(outRs1), .out_rs2_data(outRs2),
        .out_imm(outImm), .out_rd(outRd), .out_ctrl(outCtrl),
        .rf_wen(rfWen), .rf_waddr(rfWaddr), .rf_wdata(rfWdata),
        .fwd_valid(fwdValid), .fwd_wen(fwdWen), .fwd_rd(fwdRd), .fwd_data(fwdData),
        .fwd_data_ok(fwdOk), .flush(flush), .stall_cnt(stallCnt)
    );

    idu_pipe #(.XLEN(32), .NREG(16), .NFWD(3), .CNT_W(2)) dut16 (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady16),
        .in_pc(inPc), .in_inst(inInst), .out_valid(outValid16), .out_ready(outReady),
        .out_pc(outPc16), .out_inst(outInst16), .out_rs1_data(outRs1_16), .out_rs2_data(outRs2_16),
        .out_imm(outImm16), .out_rd(outRd16), .out_ctrl(outCtrl16),
        .rf_wen(rfWen), .rf_waddr(rfWaddr), .rf_wdata(rfWdata),
        .fwd_valid(fwdValid), .fwd_wen(fwdWen), .fwd_rd(fwdRd), .fwd_data(fwdData),
        .fwd_data_ok(fwdOk), .flush(flush), .stall_cnt(stallCnt16)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                                 input logic rdy, input logic fl);
        inValid  = v;
        inPc     = pc;
        inInst   = inst;
        outReady = rdy;
        flush    = fl;
    endtask

    task automatic setRf(input logic wen, input logic [4:0] addr, input logic [31:0] data);
        rfWen   = wen;
        rfWaddr = addr;
        rfWdata = data;
    endtask

    task automatic setFwd(input int i, input logic v, input logic wen, input logic [4:0] rd,
                          input logic [31:0] data, input logic ok);
        fwdValid[i]         = v;
        fwdWen[i]           = wen;
        fwdRd[i*5 +: 5]     = rd;
        fwdData[i*32 +: 32] = data;
        fwdOk[i]            = ok;
    endtask

    task automatic clearFwd();
        fwdValid = '0;
        fwdWen   = '0;
        fwdRd    = '0;
        fwdData  = '0;
        fwdOk    = '0;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        setRf(1'b0, 5'd0, 32'd0);
        clearFwd();
        rst = 1'b1;
        tick();
        tick();
    endtask

    // Reference decode built from the ISA field layout with plain arithmetic.
    function automatic void refDecode(input logic [31:0] inst, input int nreg,
                                      output logic [31:0] imm, output logic [13:0] ctrl,
                                      output logic u1, output logic u2);
        logic [31:0] sgn;
        logic [2:0]  f3;
        bit          writesRd;
        bit          known;
        bit          badReg;
        sgn      = inst[31] ? 32'hFFFF_FFFF : 32'd0;
        f3       = inst[14:12];
        ctrl     = '0;
        imm      = 32'd0;
        u1       = 1'b0;
        u2       = 1'b0;
        writesRd = 1'b0;
        known    = 1'b1;
        case (inst[6:0])
            7'h33: begin ctrl[cRType] = 1; writesRd = 1; u1 = 1; u2 = 1; end
            7'h13: begin ctrl[cIAlu] = 1; writesRd = 1; u1 = 1; imm = (sgn << 12) | 32'(inst[31:20]); end
            7'h03: begin ctrl[cMemRen] = 1; writesRd = 1; u1 = 1; imm = (sgn << 12) | 32'(inst[31:20]); end
            7'h23: begin
                ctrl[cMemWen] = 1; u1 = 1; u2 = 1;
                imm = (sgn << 12) | (32'(inst[31:25]) << 5) | 32'(inst[11:7]);
            end
            7'h63: begin
                ctrl[cBranch] = 1; u1 = 1; u2 = 1;
                imm = (sgn << 12) | (32'(inst[7]) << 11) | (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
            end
            7'h6F: begin
                ctrl[cJal] = 1; writesRd = 1;
                imm = (sgn << 20) | (32'(inst[19:12]) << 12) | (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
            end
            7'h67: begin ctrl[cJalr] = 1; writesRd = 1; u1 = 1; imm = (sgn << 12) | 32'(inst[31:20]); end
            7'h37: begin ctrl[cLui] = 1; writesRd = 1; imm = inst & 32'hFFFF_F000; end
            7'h17: begin ctrl[cAuipc] = 1; writesRd = 1; imm = inst & 32'hFFFF_F000; end
            7'h73: begin
                ctrl[cSystem] = 1;
                imm = (sgn << 12) | 32'(inst[31:20]);
                if (f3 != 0) begin
                    ctrl[cCsr] = 1; writesRd = 1; u1 = (f3 < 4);
                end
            end
            7'h0F: ctrl[cFence] = 1;
            default: known = 0;
        endcase
        badReg = (u1 && int'(inst[19:15]) >= nreg) || (u2 && int'(inst[24:20]) >= nreg) ||
                 (writesRd && int'(inst[11:7]) >= nreg);
        ctrl[cRegWen] = writesRd && (inst[11:7] != 0);
        if (!known || inst[1:0] != 2'b11 || badReg) begin
            ctrl[cIllegal] = 1;
            ctrl[cRegWen]  = 0;
            ctrl[cMemRen]  = 0;
            ctrl[cMemWen]  = 0;
        end
    endfunction

    function automatic void refOperand(input logic [4:0] rs, input logic used,
                                       output logic [31:0] val, output logic blocked);
        blocked = 1'b0;
        if (rs == 0)                       val = 32'd0;
        else if (rfWen && rfWaddr == rs)   val = rfWdata;
        else                               val = mRf[rs];
        if (used && rs != 0) begin
            for (int i = 0; i < 3; i++) begin
                if (fwdValid[i] && fwdWen[i] && fwdRd[i*5 +: 5] == rs) begin
                    val     = fwdData[i*32 +: 32];
                    blocked = !fwdOk[i];
                    break;
                end
            end
        end
    endfunction

    task automatic randomInputs();
        logic [6:0]  ops [14];
        logic [31:0] w;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37,
                7'h17, 7'h73, 7'h73, 7'h0F, 7'h7F, 7'h32};
        w        = $urandom;
        w[6:0]   = ops[$urandom_range(0, 13)];
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        applyStimulus($urandom_range(0, 3) != 0, $urandom, w,
                      $urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0);
        setRf($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
        for (int i = 0; i < 3; i++) begin
            setFwd(i, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                   5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 4) != 0);
        end
    endtask

    initial begin
        logic [31:0] eImm, v1, v2;
        logic [13:0] eCtrl;
        logic        u1, u2, h1, h2, hz, expReady;

        doReset();
        checkOutput("rst_out_valid", outValid, 0);
        checkOutput("rst_out_pc", outPc, 0);
        checkOutput("rst_out_ctrl", outCtrl, 0);
        checkOutput("rst_out_rs1", outRs1, 0);
        checkOutput("rst_out_imm", outImm, 0);
        checkOutput("rst_stall_cnt", stallCnt, 0);
        rst = 1'b0;

        // Register-file write followed by a dependent addi
        setRf(1'b1, 5'd5, 32'h1234);
        tick();
        setRf(1'b0, 5'd0, 32'd0);
        applyStimulus(1'b1, 32'h100, 32'h0012_8313, 1'b1, 1'b0);
        #1 checkOutput("t1_in_ready", inReady, 1);
        tick();
        checkOutput("t1_out_valid", outValid, 1);
        checkOutput("t1_out_pc", outPc, 32'h100);
        checkOutput("t1_rs1", outRs1, 32'h1234);
        checkOutput("t1_imm", outImm, 1);
        checkOutput("t1_reg_wen", outCtrl[cRegWen], 1);
        checkOutput("t1_rd", outRd, 6);

        // Youngest forwarding source wins
        setFwd(0, 1'b1, 1'b1, 5'd5, 32'hAAAA, 1'b1);
        setFwd(2, 1'b1, 1'b1, 5'd5, 32'hBBBB, 1'b1);
        applyStimulus(1'b1, 32'h104, 32'h0052_83B3, 1'b1, 1'b0);
        tick();
        checkOutput("t2_rs1", outRs1, 32'hAAAA);
        checkOutput("t2_rs2", outRs2, 32'hAAAA);
        checkOutput("t2_r_type", outCtrl[cRType], 1);

        // Load-use interlock for three cycles
        clearFwd();
        setFwd(0, 1'b1, 1'b1, 5'd5, 32'd0, 1'b0);
        applyStimulus(1'b1, 32'h108, 32'h0012_8313, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1 checkOutput("t3_in_ready_stall", inReady, 0);
            tick();
        end
        checkOutput("t3_stall_cnt", stallCnt, 3);
        setFwd(0, 1'b1, 1'b1, 5'd5, 32'h77, 1'b1);
        #1 checkOutput("t3_in_ready_go", inReady, 1);
        tick();
        checkOutput("t3_out_pc", outPc, 32'h108);
        checkOutput("t3_rs1", outRs1, 32'h77);
        checkOutput("t3_stall_hold", stallCnt, 3);

        // Counter saturation on the 2-bit instance, and no count while flushing
        clearFwd();
        setFwd(1, 1'b1, 1'b1, 5'd6, 32'd0, 1'b0);
        applyStimulus(1'b1, 32'h10C, 32'h0062_83B3, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) tick();
        checkOutput("sat_stall_cnt", stallCnt, 8);
        checkOutput("sat_stall_cnt16", stallCnt16, 3);
        applyStimulus(1'b1, 32'h10C, 32'h0062_83B3, 1'b1, 1'b1);
        tick();
        checkOutput("flush_no_stall_count", stallCnt, 8);
        clearFwd();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        tick();
        checkOutput("sat_drained", outValid, 0);

        // Backpressure with a second instruction waiting
        applyStimulus(1'b1, 32'h200, 32'h0050_0093, 1'b0, 1'b0);
        tick();
        checkOutput("t4_first_valid", outValid, 1);
        applyStimulus(1'b1, 32'h204, 32'h00A0_0113, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            #1 checkOutput("t4_in_ready_hold", inReady, 0);
            tick();
            checkOutput("t4_hold_pc", outPc, 32'h200);
            checkOutput("t4_hold_inst", outInst, 32'h0050_0093);
            checkOutput("t4_hold_valid", outValid, 1);
        end
        applyStimulus(1'b1, 32'h204, 32'h00A0_0113, 1'b1, 1'b0);
        #1 checkOutput("t4_release_ready", inReady, 1);
        tick();
        checkOutput("t4_second_valid", outValid, 1);
        checkOutput("t4_second_pc", outPc, 32'h204);
        checkOutput("t4_second_imm", outImm, 10);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        tick();
        checkOutput("t4_drained", outValid, 0);

        // Flush while holding, with a new instruction presented
        applyStimulus(1'b1, 32'h300, 32'h0050_0093, 1'b0, 1'b0);
        tick();
        checkOutput("t5_valid", outValid, 1);
        applyStimulus(1'b1, 32'h304, 32'h00A0_0113, 1'b0, 1'b1);
        tick();
        checkOutput("t5_flushed", outValid, 0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        tick();
        checkOutput("t5_not_captured", outValid, 0);

        // RV32E register bound, and write-through on the RV32E instance
        applyStimulus(1'b1, 32'h400, 32'h0020_88B3, 1'b1, 1'b0);
        tick();
        checkOutput("t6_e_illegal", outCtrl16[cIllegal], 1);
        checkOutput("t6_e_reg_wen", outCtrl16[cRegWen], 0);
        checkOutput("t6_i_illegal", outCtrl[cIllegal], 0);
        checkOutput("t6_i_reg_wen", outCtrl[cRegWen], 1);
        setRf(1'b1, 5'd9, 32'h55);
        applyStimulus(1'b1, 32'h404, 32'h0004_8513, 1'b1, 1'b0);
        tick();
        setRf(1'b0, 5'd0, 32'd0);
        checkOutput("t6_e_write_through", outRs1_16, 32'h55);
        checkOutput("t6_i_write_through", outRs1, 32'h55);

        // Randomized traffic against the model
        doReset();
        rst = 1'b0;
        for (int r = 0; r < 32; r++) mRf[r] = 32'd0;
        mValid = 1'b0;
        mStall = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            randomInputs();
            #1;
            refDecode(inInst, 32, eImm, eCtrl, u1, u2);
            refOperand(inInst[19:15], u1, v1, h1);
            refOperand(inInst[24:20], u2, v2, h2);
            hz       = h1 | h2;
            expReady = !hz && (!mValid || outReady);
            checkOutput("rnd_in_ready", inReady, expReady);
            @(posedge clk);
            if (flush) begin
                mValid = 1'b0;
            end else if (inValid && expReady) begin
                mValid = 1'b1;
                mPc    = inPc;
                mInst  = inInst;
                mRs1   = v1;
                mRs2   = v2;
                mImm   = eImm;
                mRd    = inInst[11:7];
                mCtrl  = eCtrl;
            end else if (mValid && outReady) begin
                mValid = 1'b0;
            end
            if (inValid && hz && !flush && mStall < 65535) mStall++;
            if (rfWen && rfWaddr != 0) mRf[rfWaddr] = rfWdata;
            #1;
            checkOutput("rnd_out_valid", outValid, mValid);
            checkOutput("rnd_stall_cnt", stallCnt, mStall);
            if (mValid) begin
                checkOutput("rnd_pc", outPc, mPc);
                checkOutput("rnd_inst", outInst, mInst);
                checkOutput("rnd_rs1", outRs1, mRs1);
                checkOutput("rnd_rs2", outRs2, mRs2);
                checkOutput("rnd_imm", outImm, mImm);
                checkOutput("rnd_rd", outRd, mRd);
                checkOutput("rnd_ctrl", outCtrl, mCtrl);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
